// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Brief    : UART boot loader; writes a length-prefixed image into
//            instruction RAM, then releases the CPU. Optional trailer
//            checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  input  logic                  data_access_fault_exception,
  output logic                  instruction_write,
  output logic [31:0]           instruction_in,
  output logic                  debug_enable,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH-2:0] words_loaded
);

  localparam int c_bit_ticks  = CLK_FREQ_HZ / BAUD;
  localparam int c_half_ticks = c_bit_ticks / 2;
  localparam int c_cnt_w      = $clog2(c_bit_ticks);
  localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_bit_ticks - 1);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_ticks - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [31:0]        c_max_words = 32'(2 ** (ADDR_WIDTH - 2));

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_HDR_LO = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] c_after_data = S_CHECK;
`else
  localparam logic [2:0] c_after_data = S_RUN;
`endif

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------- receiver
  logic [1:0]         r_rx_sync;
  logic               r_rx_prev;
  logic               w_rx;
  logic [1:0]         r_rx_state;
  logic [c_cnt_w-1:0] r_tick_cnt;
  logic [2:0]         r_bit_cnt;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic               r_frame_err;

  assign w_rx = r_rx_sync[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync    <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_rx_state   <= RX_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_sync    <= {r_rx_sync[0], uart_rx};
      r_rx_prev    <= w_rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_rx_state <= RX_START;
            r_tick_cnt <= '0;
          end
        end
        RX_START: begin
          if (r_tick_cnt == c_half_last) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            // A start bit that is already gone by mid-bit was a glitch.
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_cnt_one;
          end
        end
        RX_DATA: begin
          if (r_tick_cnt == c_bit_last) begin
            r_tick_cnt <= '0;
            r_shift    <= {w_rx, r_shift[7:1]};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_cnt_one;
          end
        end
        default: begin
          if (r_tick_cnt == c_bit_last) begin
            r_tick_cnt   <= '0;
            r_rx_state   <= RX_IDLE;
            r_byte_valid <= w_rx;
            r_frame_err  <= !w_rx;
          end else begin
            r_tick_cnt <= r_tick_cnt + c_cnt_one;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------------ loader FSM
  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic                  w_wr_nxt;
  logic [15:0]           r_n;
  logic [15:0]           w_hdr_n;
  logic [1:0]            r_byte_idx;
  logic [23:0]           r_word;
  logic                  r_wr;
  logic [31:0]           r_instr;
  logic [ADDR_WIDTH-2:0] r_words_loaded;
  logic [ADDR_WIDTH-2:0] w_words_inc;
  logic                  w_last_word;
  logic                  r_debug_enable;
  logic                  r_load_done;
  logic                  r_load_error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  assign w_hdr_n     = {r_shift, r_n[7:0]};
  assign w_words_inc = r_words_loaded + 1'b1;
  assign w_last_word = (32'(w_words_inc) == 32'(r_n));

  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = 1'b0;
    case (r_state)
      S_HDR_LO: if (r_byte_valid) w_state_nxt = S_HDR_HI;
      S_HDR_HI: begin
        if (r_byte_valid) begin
          if (w_hdr_n == 16'd0)                  w_state_nxt = c_after_data;
          else if (32'(w_hdr_n) > c_max_words)   w_state_nxt = S_ERROR;
          else                                   w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (r_byte_valid && r_byte_idx == 2'd3) begin
          w_wr_nxt = 1'b1;
          if (w_last_word) w_state_nxt = c_after_data;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (r_byte_valid) w_state_nxt = (r_shift == r_sum) ? S_RUN : S_ERROR;
      end
`endif
      S_RUN:   if (data_access_fault_exception) w_state_nxt = S_ERROR;
      S_ERROR: w_state_nxt = S_ERROR;
      default: w_state_nxt = S_ERROR;
    endcase
    // Line errors matter only while the image is still being received.
    if (r_frame_err && r_state != S_RUN && r_state != S_ERROR) begin
      w_state_nxt = S_ERROR;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state        <= S_HDR_LO;
      r_n            <= '0;
      r_byte_idx     <= '0;
      r_word         <= '0;
      r_wr           <= 1'b0;
      r_instr        <= '0;
      r_words_loaded <= '0;
      r_debug_enable <= 1'b0;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum          <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_wr    <= w_wr_nxt;
      if (r_state == S_HDR_LO && r_byte_valid) r_n[7:0]  <= r_shift;
      if (r_state == S_HDR_HI && r_byte_valid) r_n[15:8] <= r_shift;
      if (r_state == S_DATA && r_byte_valid) begin
        r_byte_idx <= r_byte_idx + 2'd1;
        case (r_byte_idx)
          2'd0:    r_word[7:0]   <= r_shift;
          2'd1:    r_word[15:8]  <= r_shift;
          2'd2:    r_word[23:16] <= r_shift;
          default: r_word        <= r_word;
        endcase
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        r_sum <= r_sum + r_shift;
`endif
      end
      if (w_wr_nxt) begin
        r_instr        <= {r_shift, r_word};
        r_words_loaded <= w_words_inc;
      end
      // Run is granted one cycle after entering RUN and dropped on the fault edge.
      r_debug_enable <= (r_state == S_RUN) && (w_state_nxt == S_RUN);
      r_load_done    <= r_load_done | (r_state == S_RUN);
      r_load_error   <= r_load_error | (w_state_nxt == S_ERROR);
    end
  end

  assign instruction_write = r_wr;
  assign instruction_in    = r_instr;
  assign debug_enable      = r_debug_enable;
  assign load_done         = r_load_done;
  assign load_error        = r_load_error;
  assign words_loaded      = r_words_loaded;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Brief    : Scoreboard bench for program_loader (writes checked by monitor).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_program_loader;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        uart_rx = 1'b1;
  logic        fault = 1'b0;
  logic        instruction_write;
  logic [31:0] instruction_in;
  logic        debug_enable;
  logic        load_done;
  logic        load_error;
  logic [14:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_wr_cyc  = 0;
  int de_rise_cyc  = 0;
  int ld_rise_cyc  = 0;
  logic prev_de = 1'b0;
  logic prev_ld = 1'b0;
  logic [31:0] exp_q[$];

  program_loader #(
    .CLK_FREQ_HZ(1000000),
    .BAUD(100000),
    .ADDR_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_rx(uart_rx),
    .data_access_fault_exception(fault),
    .instruction_write(instruction_write),
    .instruction_in(instruction_in),
    .debug_enable(debug_enable),
    .load_done(load_done),
    .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next queued word.
  always @(negedge clk) begin
    if (instruction_write === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_unexpected: actual instruction_in=0x%08h required no write", instruction_in);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (instruction_in !== e) begin
          n_fail++;
          $display("FAIL write_data: actual=0x%08h required=0x%08h", instruction_in, e);
        end
      end
      last_wr_cyc = cyc;
    end
    if (debug_enable && !prev_de) de_rise_cyc = cyc;
    if (load_done && !prev_ld) ld_rise_cyc = cyc;
    prev_de = debug_enable;
    prev_ld = load_done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(10);
    end
    uart_rx = stop_bit;
    tick(10);
    uart_rx = 1'b1;
    tick(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wr"},    32'(instruction_write), 32'd0);
    chk({tag, "_instr"}, instruction_in,          32'd0);
    chk({tag, "_dbg"},   32'(debug_enable),       32'd0);
    chk({tag, "_done"},  32'(load_done),          32'd0);
    chk({tag, "_err"},   32'(load_error),         32'd0);
    chk({tag, "_words"}, 32'(words_loaded),       32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
  endtask

  task automatic check_state(input string tag, input logic dbg, input logic done,
                             input logic err, input int words);
    chk({tag, "_dbg"},   32'(debug_enable), 32'(dbg));
    chk({tag, "_done"},  32'(load_done),    32'(done));
    chk({tag, "_err"},   32'(load_error),   32'(err));
    chk({tag, "_words"}, 32'(words_loaded), 32'(words));
  endtask

  initial begin
    tick(3);
    @(negedge clk);
    check_zero("reset");
    tick(1);
    rst = 1'b1;
    tick(4);

    // Two-word image.
    exp_q.push_back(32'h0000_0013);
    exp_q.push_back(32'h0010_0093);
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hB6, 1'b1);
`else
    chk("img2_dbg_latency",  32'(de_rise_cyc - last_wr_cyc), 32'd1);
    chk("img2_done_latency", 32'(ld_rise_cyc - last_wr_cyc), 32'd1);
`endif
    tick(2);
    check_state("img2", 1'b1, 1'b1, 1'b0, 2);

    // Empty image; a fault before RUN must be ignored.
    do_reset();
    fault = 1'b1; tick(1); fault = 1'b0;
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    tick(2);
    check_state("empty", 1'b1, 1'b1, 1'b0, 0);

    // Oversized length.
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h40, 1'b1);
    tick(2);
    check_state("toobig", 1'b0, 1'b0, 1'b1, 0);

    // Framing error on the 3rd data byte; later bytes must not complete a word.
    do_reset();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b1);
    tick(2);
    check_state("frame", 1'b0, 1'b0, 1'b1, 0);

    // Short glitch on idle line, then an empty image must still be accepted.
    do_reset();
    uart_rx = 1'b0; tick(3); uart_rx = 1'b1; tick(20);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    tick(2);
    check_state("glitch", 1'b1, 1'b1, 1'b0, 0);

    // Fault in RUN drops debug_enable on the next edge.
    fault = 1'b1; tick(1); fault = 1'b0;
    @(negedge clk);
    chk("fault_dbg", 32'(debug_enable), 32'd0);
    chk("fault_err", 32'(load_error),   32'd1);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    tick(1);
    rst = 1'b1;
    tick(4);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b1);
`endif
    tick(2);
    check_state("rehdr", 1'b1, 1'b1, 1'b0, 0);

    // One-word image with correct trailer (ignored without checksum).
    do_reset();
    exp_q.push_back(32'h0403_0201);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(2);
    check_state("csum_ok", 1'b1, 1'b1, 1'b0, 1);

    // Same image with wrong trailer.
    do_reset();
    exp_q.push_back(32'h0403_0201);
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0B, 1'b1);
    tick(2);
    check_state("csum_bad", !CSUM, !CSUM, CSUM, 1);

    tick(2);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
